match_sched_ctrl: RTL
=====================

// Module: match_sched_ctrl
// PURPOSE
//  Next-gen scheduler for the phase-matching pipeline. Per frame, routes alternating
//  reference rows to the match cache and target rows, position-tagged, to the per-lane phase buffers.
//  Returns per-lane disparity results as an AXI stream with row/frame markers.
//  Adds over the previous generation:
//   - configurable row order and rows per frame
//   - in-flight row throttling
//   - stall-safe position counting
//   - row-length error detection
// PARAMETERS
//  ROW_SIZE     1280  pixels per row; must be a multiple of BEAT_SIZE
//  BEAT_SIZE    8     pixels (lanes) per beat
//  DATA_WIDTH   16    bits per pixel/phase/disparity; also position-tag width
//  ROW_CNT_W    11    width of row counters and cfg_rows
//  REF_FIRST    1     1: ref row then target row per pair; 0: target then ref
//  MAX_INFLIGHT 2     max target rows written whose results are not yet fully output
// PORTS
//  clk                 in   1                          clock, all logic rising-edge
//  rst                 in   1                          synchronous, active-high reset
//  start               in   1                          pulse: begin frame (accepted only in IDLE)
//  cfg_rows            in   ROW_CNT_W                  row pairs per frame, latched on accepted start
//  busy                out  1                          high whenever state != IDLE
//  frame_done          out  1                          1-cycle pulse on DRAIN->IDLE
//  err_len             out  1                          sticky: row tlast at wrong beat
//  s_axis_tdata        in   BEAT_SIZE*DATA_WIDTH       input phase beat, lane i = bits[i*DW+:DW]
//  s_axis_tvalid       in   1                          AXIS valid
//  s_axis_tready       out  1                          AXIS ready
//  s_axis_tlast        in   1                          last beat of a row
//  m_cache_axis_tdata  out  BEAT_SIZE*DATA_WIDTH       ref row to cache (= s_axis_tdata)
//  m_cache_axis_tvalid out  1                          cache valid
//  m_cache_axis_tready in   1                          cache ready
//  m_cache_axis_tlast  out  1                          = s_axis_tlast
//  phase_buf_wr_en     out  1                          write all lane buffers
//  phase_buf_din       out  BEAT_SIZE*(2*DATA_WIDTH+1) lane i: {tlast, pos_i, data_i}
//  phase_buf_pfull     in   BEAT_SIZE                  per-lane prog-full
//  dis_buf_rd_en       out  BEAT_SIZE                  per-lane result pop
//  dis_buf_empty       in   BEAT_SIZE                  per-lane result empty
//  dis_buf_dout        in   BEAT_SIZE*(DATA_WIDTH+1)   lane i: {row_last, disparity}
//  m_axis_tdata        out  BEAT_SIZE*DATA_WIDTH       disparity beat
//  m_axis_tvalid       out  1                          result valid
//  m_axis_tready       in   1                          result ready
//  m_axis_tlast        out  1                          last beat of a result row
//  m_axis_tuser        out  1                          last beat of a frame (tlast of final row)
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - state=IDLE; all counters 0; err_len=0
//   - busy, frame_done, s_axis_tready, m_cache_axis_tvalid, phase_buf_wr_en, dis_buf_rd_en, m_axis_tvalid = 0
//   - mid-frame reset abandons the frame; downstream buffers are flushed externally.
//  FSM IDLE->FIRST on start. FIRST->SECOND and SECOND->FIRST on an accepted tlast beat.
//   - FIRST/SECOND = REF/TGT when REF_FIRST=1, else TGT/REF.
//   - A pair completes on the accepted tlast of SECOND; pair_cnt++.
//   - If pair_cnt == rows-1 at that point: ->DRAIN, else ->FIRST.
//   - DRAIN->IDLE once out_rows == rows; frame_done pulses that cycle.
//   - rows = latched cfg_rows; cfg_rows = 0 is treated as 1.
//  REF state: cache path active.
//   - m_cache_axis_tvalid = s_axis_tvalid; s_axis_tready = m_cache_axis_tready; phase_buf_wr_en = 0
//  TGT state: buffer path active.
//   - s_axis_tready = ~|phase_buf_pfull & (inflight < MAX_INFLIGHT); cache valid = 0
//   - phase_buf_wr_en = s_axis_tvalid & s_axis_tready
//  IDLE/DRAIN: s_axis_tready = 0.
//  inflight = tgt_rows_written - out_rows.
//   - tgt_rows_written increments on the accepted TGT tlast.
//   - A simultaneous increment and decrement leaves inflight unchanged.
//  Position tagging:
//   - beat_cnt advances only on an accepted beat; clears on accepted tlast; holds during stalls.
//   - pos_i = beat_cnt*BEAT_SIZE + i (DATA_WIDTH bits); tag bit = s_axis_tlast.
//  Row length:
//   - Accepted tlast with beat_cnt != ROW_SIZE/BEAT_SIZE-1 sets err_len.
//   - Row still ends on that tlast.
//   - A missing tlast does not stop beat_cnt; it wraps at its width.
//  Result path, combinational, 0-cycle latency:
//   - m_axis_tvalid = ~|dis_buf_empty (all lanes ready)
//   - dis_buf_rd_en = {BEAT_SIZE{m_axis_tvalid & m_axis_tready}}
//   - m_axis_tdata lane i = dis_buf_dout[i][DW-1:0]; tlast = dis_buf_dout[0][DW]
//   - out_rows++ on each accepted tlast.
//   - m_axis_tuser = m_axis_tlast & (out_rows == rows-1) & busy
//  The result path stays active in all states, including IDLE; results never stall on state.
// TESTING
//  rows=2, REF_FIRST=1, free flow, 160 beats/row:
//   -> rows 0,2 reach cache; rows 1,3 reach buffers; frame_done exactly once; busy returns to 0.
//  REF_FIRST=0, rows=1 -> first row written to buffers, second row to cache.
//  Stall mid-TGT row (tvalid low 5 cycles at beat 40) -> pos of beat 41 lane 0 = 328; no reset to 0.
//  MAX_INFLIGHT=2, results held (all empty), rows=4:
//   -> s_axis_tready=0 in 3rd TGT row; resumes 1 cycle after first result tlast accepted.
//  Tlast at beat 99 -> err_len=1 and sticky; next row is routed to the opposite path.
//  rst asserted mid-DRAIN -> next cycle busy=0, all valids/enables 0; new start then runs a clean frame.

Source files
------------

// File: rtl/match_sched_ctrl.sv
// rtl/match_sched_ctrl.sv - per-frame row scheduler: ref rows to match cache, tagged target rows to phase buffers, results out
module match_sched_ctrl #(
    parameter int ROW_SIZE     = 1280,
    parameter int BEAT_SIZE    = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int ROW_CNT_W    = 11,
    parameter int REF_FIRST    = 1,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [ROW_CNT_W-1:0]                   cfg_rows,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   err_len,
    input  logic [BEAT_SIZE*DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tlast,
    output logic [BEAT_SIZE*DATA_WIDTH-1:0]        m_cache_axis_tdata,
    output logic                                   m_cache_axis_tvalid,
    input  logic                                   m_cache_axis_tready,
    output logic                                   m_cache_axis_tlast,
    output logic                                   phase_buf_wr_en,
    output logic [BEAT_SIZE*(2*DATA_WIDTH+1)-1:0]  phase_buf_din,
    input  logic [BEAT_SIZE-1:0]                   phase_buf_pfull,
    output logic [BEAT_SIZE-1:0]                   dis_buf_rd_en,
    input  logic [BEAT_SIZE-1:0]                   dis_buf_empty,
    input  logic [BEAT_SIZE*(DATA_WIDTH+1)-1:0]    dis_buf_dout,
    output logic [BEAT_SIZE*DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic                                   m_axis_tuser
);
    localparam int BEATS  = ROW_SIZE / BEAT_SIZE;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANE_W = 2 * DATA_WIDTH + 1;
    localparam int RES_W  = DATA_WIDTH + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_SECOND = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic                 FIRST_IS_REF = (REF_FIRST != 0);
    localparam logic [ROW_CNT_W-1:0] ONE          = ROW_CNT_W'(1);
    localparam logic [ROW_CNT_W-1:0] MAX_INF      = ROW_CNT_W'(MAX_INFLIGHT);
    localparam logic [BEAT_W-1:0]    LAST_BEAT    = BEAT_W'(BEATS - 1);

    logic [1:0]           state_q, state_d;
    logic [ROW_CNT_W-1:0] rows_q, rows_d;
    logic [ROW_CNT_W-1:0] pair_cnt_q, pair_cnt_d;
    logic [ROW_CNT_W-1:0] out_rows_q, out_rows_d;
    logic [ROW_CNT_W-1:0] tgt_rows_q, tgt_rows_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                 err_len_q, err_len_d;

    logic                 in_ref, in_tgt, s_fire, s_last_fire, res_fire, res_last_fire;
    logic [ROW_CNT_W-1:0] inflight;
    logic [BEAT_SIZE-1:0] lane_last_unused;

    assign in_ref = ((state_q == ST_FIRST) && FIRST_IS_REF) || ((state_q == ST_SECOND) && !FIRST_IS_REF);
    assign in_tgt = ((state_q == ST_FIRST) && !FIRST_IS_REF) || ((state_q == ST_SECOND) && FIRST_IS_REF);
    assign inflight = tgt_rows_q - out_rows_q;

    always_comb begin
        s_axis_tready = 1'b0;
        if (in_ref) begin
            s_axis_tready = m_cache_axis_tready;
        end else if (in_tgt) begin
            s_axis_tready = ~|phase_buf_pfull & (inflight < MAX_INF);
        end
    end

    assign s_fire              = s_axis_tvalid & s_axis_tready;
    assign s_last_fire         = s_fire & s_axis_tlast;
    assign m_cache_axis_tdata  = s_axis_tdata;
    assign m_cache_axis_tlast  = s_axis_tlast;
    assign m_cache_axis_tvalid = in_ref & s_axis_tvalid;
    assign phase_buf_wr_en     = in_tgt & s_fire;

    // Position tags come from the held beat count, so stalls never disturb them.
    for (genvar i = 0; i < BEAT_SIZE; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] pos;
        assign pos = DATA_WIDTH'(beat_cnt_q) * DATA_WIDTH'(BEAT_SIZE) + DATA_WIDTH'(i);
        assign phase_buf_din[i*LANE_W +: LANE_W] =
            {s_axis_tlast, pos, s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]};
        assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = dis_buf_dout[i*RES_W +: DATA_WIDTH];
        assign lane_last_unused[i] = dis_buf_dout[i*RES_W + DATA_WIDTH];
    end

    assign m_axis_tvalid = ~|dis_buf_empty;
    assign m_axis_tlast  = dis_buf_dout[DATA_WIDTH];
    assign res_fire      = m_axis_tvalid & m_axis_tready;
    assign res_last_fire = res_fire & m_axis_tlast;
    assign dis_buf_rd_en = {BEAT_SIZE{res_fire}};
    assign busy          = (state_q != ST_IDLE);
    assign m_axis_tuser  = m_axis_tlast & (out_rows_q == rows_q - ONE) & busy;
    assign frame_done    = (state_q == ST_DRAIN) && (out_rows_q == rows_q);
    assign err_len       = err_len_q;

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        pair_cnt_d = pair_cnt_q;
        out_rows_d = out_rows_q;
        tgt_rows_d = tgt_rows_q;
        beat_cnt_d = beat_cnt_q;
        err_len_d  = err_len_q;
        if (s_fire) begin
            beat_cnt_d = s_axis_tlast ? '0 : beat_cnt_q + BEAT_W'(1);
        end
        if (s_last_fire && (beat_cnt_q != LAST_BEAT)) begin
            err_len_d = 1'b1;
        end
        if (in_tgt && s_last_fire) begin
            tgt_rows_d = tgt_rows_q + ONE;
        end
        if (res_last_fire) begin
            out_rows_d = out_rows_q + ONE;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FIRST;
                    rows_d     = (cfg_rows == '0) ? ONE : cfg_rows;
                    pair_cnt_d = '0;
                    out_rows_d = '0;
                    tgt_rows_d = '0;
                    beat_cnt_d = '0;
                end
            end
            ST_FIRST: begin
                if (s_last_fire) state_d = ST_SECOND;
            end
            ST_SECOND: begin
                if (s_last_fire) begin
                    pair_cnt_d = pair_cnt_q + ONE;
                    state_d    = (pair_cnt_q == rows_q - ONE) ? ST_DRAIN : ST_FIRST;
                end
            end
            ST_DRAIN: begin
                if (frame_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            pair_cnt_q <= '0;
            out_rows_q <= '0;
            tgt_rows_q <= '0;
            beat_cnt_q <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            pair_cnt_q <= pair_cnt_d;
            out_rows_q <= out_rows_d;
            tgt_rows_q <= tgt_rows_d;
            beat_cnt_q <= beat_cnt_d;
            err_len_q  <= err_len_d;
        end
    end
endmodule
